// File: rtl/kalman_sequencer.sv
// Per-frame command sequencer for the kalman datapath: INIT / PREDICT / UPDATE, coast and track-loss tracking.
// Latency: frame_start -> cmd_valid next cycle; dp_done after PREDICT with pending measurement -> UPDATE next cycle.
// Backpressure: command held stable until cmd_ready; frame_start while busy is dropped and flagged.
module kalman_sequencer #(
    parameter int DISP_WIDTH = 11,
    parameter int MAX_MISS   = 8,
    parameter int TIMEOUT    = 1023,
    parameter int MISS_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  meas_valid,
    input  logic [DISP_WIDTH-1:0] meas_x,
    input  logic [DISP_WIDTH-1:0] meas_y,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [DISP_WIDTH-1:0] cmd_x,
    output logic [DISP_WIDTH-1:0] cmd_y,
    input  logic                  dp_done,
    output logic                  busy,
    output logic                  track_valid,
    output logic [MISS_W-1:0]     miss_count,
    output logic                  track_lost,
    output logic                  frame_drop,
    output logic                  err_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_INIT    = 2'b00;
    localparam logic [1:0] OP_PREDICT = 2'b01;
    localparam logic [1:0] OP_UPDATE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [DISP_WIDTH-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [DISP_WIDTH-1:0]   mx_q, my_q;
    logic                    pend_q, pend_clr;
    logic [TMR_W-1:0]        timer_q, timer_d, timer_inc;
    logic                    tv_q, tv_d;
    logic [MISS_W-1:0]       miss_q, miss_d, miss_inc;
    logic                    lost_d, drop_d, tmo_d;
    logic                    lost_q, drop_q, tmo_q;

    assign timer_inc = timer_q + 1'b1;
    assign miss_inc  = miss_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        timer_d  = timer_q;
        tv_d     = tv_q;
        miss_d   = miss_q;
        lost_d   = 1'b0;
        drop_d   = 1'b0;
        tmo_d    = 1'b0;
        pend_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Decision uses the registered pend flag, so a same-cycle measurement waits a frame.
                if (frame_start) begin
                    if (tv_q) begin
                        state_d = ST_ISSUE;
                        op_d    = OP_PREDICT;
                        cx_d    = mx_q;
                        cy_d    = my_q;
                    end else if (pend_q) begin
                        state_d = ST_ISSUE;
                        op_d    = OP_INIT;
                        cx_d    = mx_q;
                        cy_d    = my_q;
                    end
                end
            end
            ST_ISSUE: begin
                drop_d = frame_start;
                if (cmd_ready) begin
                    state_d  = ST_WAIT;
                    timer_d  = '0;
                    pend_clr = (op_q != OP_PREDICT);
                end
            end
            ST_WAIT: begin
                drop_d = frame_start;
                if (dp_done) begin
                    state_d = ST_IDLE;
                    if (op_q == OP_INIT) begin
                        tv_d   = 1'b1;
                        miss_d = '0;
                    end else if (op_q == OP_PREDICT) begin
                        if (pend_q) begin
                            state_d = ST_ISSUE;
                            op_d    = OP_UPDATE;
                            cx_d    = mx_q;
                            cy_d    = my_q;
                        end else if (miss_inc == MISS_W'(MAX_MISS)) begin
                            lost_d = 1'b1;
                            tv_d   = 1'b0;
                            miss_d = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end else if (timer_inc == TMR_W'(TIMEOUT)) begin
                    // Hung datapath: abandon the track entirely and start over from INIT.
                    tmo_d    = 1'b1;
                    tv_d     = 1'b0;
                    miss_d   = '0;
                    pend_clr = 1'b1;
                    timer_d  = timer_inc;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_INIT;
            cx_q    <= '0;
            cy_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            pend_q  <= 1'b0;
            timer_q <= '0;
            tv_q    <= 1'b0;
            miss_q  <= '0;
            lost_q  <= 1'b0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            timer_q <= timer_d;
            tv_q    <= tv_d;
            miss_q  <= miss_d;
            lost_q  <= lost_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
            if (meas_valid) begin
                mx_q   <= meas_x;
                my_q   <= meas_y;
                pend_q <= 1'b1;
            end else if (pend_clr) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_op      = op_q;
    assign cmd_x       = cx_q;
    assign cmd_y       = cy_q;
    assign busy        = (state_q != ST_IDLE);
    assign track_valid = tv_q;
    assign miss_count  = miss_q;
    assign track_lost  = lost_q;
    assign frame_drop  = drop_q;
    assign err_timeout = tmo_q;

endmodule
